// File: rtl/i2c_word_write.sv
// i2c_word_write: single-master I2C engine that writes address, pointer and a 16-bit word, with an ACK check after each byte.
module i2c_word_write #(
    parameter int CLK_DIV = 125
) (
    input  logic        SYS_CLK,
    input  logic        RESET,
    input  logic        W_WORD_GO,
    input  logic [7:0]  SLAVE_ADDR,
    input  logic [7:0]  POINTER,
    input  logic [15:0] WORD_DATA,
    input  logic        I2C_SDA_IN,
    output logic        I2C_SCL,
    output logic        I2C_SDA_O,
    output logic        I2C_SDA_OE,
    output logic        W_WORD_END,
    output logic        ACK_ERR,
    output logic [7:0]  WORD_ST,
    output logic [7:0]  WORD_CNT,
    output logic [7:0]  WORD_BYTE
);
    localparam int DW = $clog2(CLK_DIV);
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE} state_t;
    state_t          st, st_n;
    logic [DW-1:0]   div, div_n;
    logic [1:0]      tq, tq_n, idx, idx_n;
    logic [2:0]      cnt, cnt_n;
    logic [3:0][7:0] bytes_q;
    logic [7:0]      byte_n;
    logic            tick, slot_end, ack_n, load, bit_n, scl_n, oe_n;
    always_comb begin
        tick = div == DW'(CLK_DIV - 1);
        slot_end = tick && tq == 2'd3;
        st_n = st;
        div_n = tick ? '0 : div + 1'b1;
        tq_n = tq + {1'b0, tick};
        cnt_n = cnt;
        idx_n = idx;
        ack_n = ACK_ERR;
        load = 1'b0;
        case (st)
            S_IDLE: begin
                div_n = '0;
                tq_n = '0;
                if (W_WORD_GO) begin
                    st_n = S_START;
                    idx_n = '0;
                    ack_n = 1'b0;
                    load = 1'b1;
                end
            end
            S_START: if (slot_end) begin
                st_n = S_BIT;
                cnt_n = 3'd7;
            end
            S_BIT: if (slot_end) begin
                if (cnt == 3'd0) st_n = S_ACK;
                else cnt_n = cnt - 1'b1;
            end
            S_ACK: begin
                // slave sampled on the last cycle of the high phase
                if (tick && tq == 2'd2 && I2C_SDA_IN) ack_n = 1'b1;
                if (slot_end) begin
                    if (ACK_ERR || idx == 2'd3) st_n = S_STOP;
                    else begin
                        st_n = S_BIT;
                        idx_n = idx + 1'b1;
                        cnt_n = 3'd7;
                    end
                end
            end
            S_STOP: if (slot_end) st_n = S_DONE;
            S_DONE: begin
                st_n = S_IDLE;
                div_n = '0;
                tq_n = '0;
            end
            default: st_n = S_IDLE;
        endcase
        // outputs are decoded from next-state values so they leave the flops directly
        byte_n = load ? {SLAVE_ADDR[7:1], 1'b0} : bytes_q[idx_n];
        bit_n = byte_n[cnt_n];
        scl_n = st_n == S_START ? tq_n != 2'd3 :
                (st_n == S_BIT || st_n == S_ACK) ? (tq_n == 2'd1 || tq_n == 2'd2) :
                st_n == S_STOP ? tq_n != 2'd0 : 1'b1;
        oe_n = st_n == S_START ? tq_n != 2'd0 :
               st_n == S_BIT ? !bit_n :
               st_n == S_STOP ? tq_n != 2'd3 : 1'b0;
    end
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            st <= S_IDLE;
            div <= '0;
            tq <= '0;
            cnt <= '0;
            idx <= '0;
            bytes_q <= '0;
            ACK_ERR <= 1'b0;
            I2C_SCL <= 1'b1;
            I2C_SDA_OE <= 1'b0;
            W_WORD_END <= 1'b0;
            WORD_BYTE <= '0;
        end else begin
            st <= st_n;
            div <= div_n;
            tq <= tq_n;
            cnt <= cnt_n;
            idx <= idx_n;
            if (load) bytes_q <= {WORD_DATA[7:0], WORD_DATA[15:8], POINTER, SLAVE_ADDR[7:1], 1'b0};
            ACK_ERR <= ack_n;
            I2C_SCL <= scl_n;
            I2C_SDA_OE <= oe_n;
            W_WORD_END <= st_n == S_DONE;
            WORD_BYTE <= st_n == S_IDLE ? 8'd0 : byte_n;
        end
    end
    assign I2C_SDA_O = 1'b0;
    assign WORD_ST = {5'd0, st};
    assign WORD_CNT = {5'd0, cnt};
endmodule

// File: tb/tb_i2c_word_write.sv
// tb_i2c_word_write: directed tests of the I2C word writer against an open-drain bus and slave model.
module tb_i2c_word_write;
    localparam int CD = 4;
    logic        SYS_CLK = 1'b0, RESET = 1'b1, W_WORD_GO = 1'b0;
    logic [7:0]  SLAVE_ADDR = 8'h00, POINTER = 8'h00;
    logic [15:0] WORD_DATA = 16'h0000;
    logic        I2C_SDA_IN, I2C_SCL, I2C_SDA_O, I2C_SDA_OE, W_WORD_END, ACK_ERR;
    logic [7:0]  WORD_ST, WORD_CNT, WORD_BYTE;
    int n_cmp = 0, n_fail = 0;
    int nack_at = -1;
    int clr_req = 0, clr_ack = 0;
    int nb, starts, stops, bus_err, bitn, run;
    logic pull = 1'b0, in_frame, first_fall, scl_q = 1'b1, sda_q = 1'b1;
    logic [7:0] sh;
    logic [7:0] mb [8];

    i2c_word_write #(.CLK_DIV(CD)) dut (
        .SYS_CLK(SYS_CLK), .RESET(RESET), .W_WORD_GO(W_WORD_GO),
        .SLAVE_ADDR(SLAVE_ADDR), .POINTER(POINTER), .WORD_DATA(WORD_DATA),
        .I2C_SDA_IN(I2C_SDA_IN), .I2C_SCL(I2C_SCL), .I2C_SDA_O(I2C_SDA_O),
        .I2C_SDA_OE(I2C_SDA_OE), .W_WORD_END(W_WORD_END), .ACK_ERR(ACK_ERR),
        .WORD_ST(WORD_ST), .WORD_CNT(WORD_CNT), .WORD_BYTE(WORD_BYTE));

    always #5 SYS_CLK = ~SYS_CLK;
    assign I2C_SDA_IN = !(I2C_SDA_OE || pull);

    // open-drain bus monitor and slave: decodes bytes, ACKs all bytes except nack_at, checks SCL timing
    always @(negedge SYS_CLK) begin
        if (clr_req != clr_ack) begin
            clr_ack = clr_req;
            nb = 0; starts = 0; stops = 0; bus_err = 0; bitn = 0; run = 1;
            pull = 1'b0; in_frame = 1'b0; first_fall = 1'b0;
            scl_q = I2C_SCL; sda_q = I2C_SDA_IN;
        end else begin
            if (I2C_SCL && scl_q && I2C_SDA_IN != sda_q) begin
                if (!I2C_SDA_IN) begin starts++; in_frame = 1'b1; bitn = 0; first_fall = 1'b1; end
                else begin stops++; in_frame = 1'b0; end
            end
            if (I2C_SCL != scl_q) begin
                if (in_frame && I2C_SCL && run != 2 * CD) bus_err++;
                if (in_frame && !I2C_SCL && !first_fall && run != 2 * CD) bus_err++;
                if (in_frame && I2C_SCL) begin
                    if (bitn < 8) begin
                        sh = {sh[6:0], I2C_SDA_IN};
                        if (bitn == 7) begin if (nb < 8) mb[nb] = sh; nb++; end
                    end
                    bitn++;
                end
                if (in_frame && !I2C_SCL) begin
                    first_fall = 1'b0;
                    if (bitn == 8) pull = (nb - 1 != nack_at);
                    else if (bitn == 9) begin pull = 1'b0; bitn = 0; end
                end
                run = 1;
            end else run++;
            scl_q = I2C_SCL; sda_q = I2C_SDA_IN;
        end
    end

    task automatic mon_clear();
        clr_req = clr_req + 1;
        repeat (2) @(posedge SYS_CLK);
    endtask

    task automatic do_txn(input int ga, input int gb, output int cyc, output int ends, output logic ack1);
        cyc = -1; ends = 0; ack1 = 1'bx;
        @(negedge SYS_CLK); W_WORD_GO = 1'b1;
        @(posedge SYS_CLK); #1;
        W_WORD_GO = 1'b0;
        SLAVE_ADDR = 8'h3C; POINTER = 8'hFF; WORD_DATA = 16'hFFFF;
        for (int c = 1; c < 3000; c++) begin
            if (c == 1) ack1 = ACK_ERR;
            if (W_WORD_END) begin ends++; if (cyc < 0) cyc = c; end
            if (cyc > 0 && c > cyc + 20) break;
            W_WORD_GO = (c == ga || c == gb);
            @(posedge SYS_CLK); #1;
        end
        W_WORD_GO = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge SYS_CLK);
        #1;
        n_cmp++; if (WORD_ST !== 8'd0) begin n_fail++; $display("FAIL reset_st got %h want 00", WORD_ST); end
        n_cmp++; if (WORD_CNT !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 00", WORD_CNT); end
        n_cmp++; if (WORD_BYTE !== 8'd0) begin n_fail++; $display("FAIL reset_byte got %h want 00", WORD_BYTE); end
        n_cmp++; if ({I2C_SCL, I2C_SDA_O, I2C_SDA_OE} !== 3'b100) begin n_fail++; $display("FAIL reset_bus got %b want 100", {I2C_SCL, I2C_SDA_O, I2C_SDA_OE}); end
        n_cmp++; if ({W_WORD_END, ACK_ERR} !== 2'b00) begin n_fail++; $display("FAIL reset_end_ack got %b want 00", {W_WORD_END, ACK_ERR}); end
        RESET = 1'b0;
        mon_clear();
    endtask

    task automatic test_normal(input string tag);
        int cyc, ends;
        logic a1;
        nack_at = -1;
        SLAVE_ADDR = 8'h80; POINTER = 8'h02; WORD_DATA = 16'h1000;
        mon_clear();
        do_txn(0, 0, cyc, ends, a1);
        n_cmp++; if (cyc !== 609) begin n_fail++; $display("FAIL %s_end_cycle got %0d want 609", tag, cyc); end
        n_cmp++; if (ends !== 1) begin n_fail++; $display("FAIL %s_end_count got %0d want 1", tag, ends); end
        n_cmp++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL %s_ack_cleared_on_go got %b want 0", tag, a1); end
        n_cmp++; if (nb !== 4) begin n_fail++; $display("FAIL %s_nbytes got %0d want 4", tag, nb); end
        n_cmp++; if ({mb[0], mb[1], mb[2], mb[3]} !== 32'h80021000) begin n_fail++; $display("FAIL %s_bytes got %h want 80021000", tag, {mb[0], mb[1], mb[2], mb[3]}); end
        n_cmp++; if ({starts, stops} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL %s_start_stop got %0d/%0d want 1/1", tag, starts, stops); end
        n_cmp++; if (bus_err !== 0) begin n_fail++; $display("FAIL %s_bus_timing got %0d want 0", tag, bus_err); end
        n_cmp++; if (ACK_ERR !== 1'b0) begin n_fail++; $display("FAIL %s_ack_err got %b want 0", tag, ACK_ERR); end
        n_cmp++; if (I2C_SDA_O !== 1'b0) begin n_fail++; $display("FAIL %s_sda_o got %b want 0", tag, I2C_SDA_O); end
    endtask

    task automatic test_addr_nack();
        int cyc, ends;
        logic a1;
        nack_at = 0;
        SLAVE_ADDR = 8'h80; POINTER = 8'h02; WORD_DATA = 16'h1000;
        mon_clear();
        do_txn(0, 0, cyc, ends, a1);
        n_cmp++; if (cyc !== 177) begin n_fail++; $display("FAIL addr_nack_end_cycle got %0d want 177", cyc); end
        n_cmp++; if (nb !== 1 || mb[0] !== 8'h80) begin n_fail++; $display("FAIL addr_nack_bytes got %0d/%h want 1/80", nb, mb[0]); end
        n_cmp++; if (stops !== 1) begin n_fail++; $display("FAIL addr_nack_stop got %0d want 1", stops); end
        n_cmp++; if (bus_err !== 0) begin n_fail++; $display("FAIL addr_nack_bus_timing got %0d want 0", bus_err); end
        repeat (30) @(posedge SYS_CLK);
        #1;
        n_cmp++; if (ACK_ERR !== 1'b1) begin n_fail++; $display("FAIL addr_nack_ack_err_held got %b want 1", ACK_ERR); end
    endtask

    task automatic test_data_nack();
        int cyc, ends;
        logic a1;
        nack_at = 2;
        SLAVE_ADDR = 8'h80; POINTER = 8'h02; WORD_DATA = 16'h10AB;
        mon_clear();
        do_txn(0, 0, cyc, ends, a1);
        n_cmp++; if (cyc !== 465) begin n_fail++; $display("FAIL data_nack_end_cycle got %0d want 465", cyc); end
        n_cmp++; if (nb !== 3 || {mb[0], mb[1], mb[2]} !== 24'h800210) begin n_fail++; $display("FAIL data_nack_bytes got %0d/%h want 3/800210", nb, {mb[0], mb[1], mb[2]}); end
        n_cmp++; if (ACK_ERR !== 1'b1) begin n_fail++; $display("FAIL data_nack_ack_err got %b want 1", ACK_ERR); end
        n_cmp++; if (stops !== 1 || bus_err !== 0) begin n_fail++; $display("FAIL data_nack_bus got %0d/%0d want 1/0", stops, bus_err); end
    endtask

    task automatic test_go_ignored();
        int cyc, ends;
        logic a1;
        nack_at = -1;
        SLAVE_ADDR = 8'h81; POINTER = 8'h5A; WORD_DATA = 16'hC3F0;
        mon_clear();
        do_txn(10, 300, cyc, ends, a1);
        n_cmp++; if (ends !== 1 || cyc !== 609) begin n_fail++; $display("FAIL go_ignored_end got %0d@%0d want 1@609", ends, cyc); end
        n_cmp++; if (nb !== 4 || {mb[0], mb[1], mb[2], mb[3]} !== 32'h805AC3F0) begin n_fail++; $display("FAIL go_ignored_bytes got %0d/%h want 4/805ac3f0", nb, {mb[0], mb[1], mb[2], mb[3]}); end
        n_cmp++; if (starts !== 1) begin n_fail++; $display("FAIL go_ignored_starts got %0d want 1", starts); end
        mon_clear();
        do_txn(609, 0, cyc, ends, a1);
        n_cmp++; if (ends !== 1 || WORD_ST !== 8'd0) begin n_fail++; $display("FAIL go_in_done got ends=%0d st=%h want 1/00", ends, WORD_ST); end
        n_cmp++; if (starts !== 1) begin n_fail++; $display("FAIL go_in_done_starts got %0d want 1", starts); end
    endtask

    task automatic test_back_to_back();
        int c;
        nack_at = -1;
        SLAVE_ADDR = 8'h80; POINTER = 8'h02; WORD_DATA = 16'h1000;
        mon_clear();
        @(negedge SYS_CLK); W_WORD_GO = 1'b1;
        c = 0;
        while (!W_WORD_END && c < 2000) begin @(posedge SYS_CLK); #1; c++; end
        n_cmp++; if (WORD_ST !== 8'd5) begin n_fail++; $display("FAIL held_go_done_st got %h want 05", WORD_ST); end
        @(posedge SYS_CLK); #1;
        n_cmp++; if (WORD_ST !== 8'd0) begin n_fail++; $display("FAIL held_go_idle_st got %h want 00", WORD_ST); end
        @(posedge SYS_CLK); #1;
        n_cmp++; if (WORD_ST !== 8'd1) begin n_fail++; $display("FAIL held_go_restart_st got %h want 01", WORD_ST); end
        W_WORD_GO = 1'b0;
        c = 1;
        while (!W_WORD_END && c < 2000) begin @(posedge SYS_CLK); #1; c++; end
        n_cmp++; if (c !== 609) begin n_fail++; $display("FAIL held_go_second_end got %0d want 609", c); end
        repeat (5) @(posedge SYS_CLK);
        n_cmp++; if (nb !== 8 || mb[4] !== 8'h80 || mb[7] !== 8'h00) begin n_fail++; $display("FAIL held_go_bytes got %0d/%h/%h want 8/80/00", nb, mb[4], mb[7]); end
        n_cmp++; if (starts !== 2 || stops !== 2 || bus_err !== 0) begin n_fail++; $display("FAIL held_go_bus got %0d/%0d/%0d want 2/2/0", starts, stops, bus_err); end
    endtask

    task automatic test_reset_mid();
        int ends;
        nack_at = -1;
        SLAVE_ADDR = 8'h80; POINTER = 8'h02; WORD_DATA = 16'h1000;
        mon_clear();
        @(negedge SYS_CLK); W_WORD_GO = 1'b1;
        @(posedge SYS_CLK); #1;
        W_WORD_GO = 1'b0;
        ends = 0;
        for (int c = 1; c < 200; c++) begin @(posedge SYS_CLK); #1; if (W_WORD_END) ends++; end
        n_cmp++; if ({WORD_ST, WORD_CNT, WORD_BYTE} !== 24'h020502) begin n_fail++; $display("FAIL mid_probe got %h want 020502", {WORD_ST, WORD_CNT, WORD_BYTE}); end
        RESET = 1'b1;
        @(posedge SYS_CLK); #1;
        RESET = 1'b0;
        n_cmp++; if ({I2C_SCL, I2C_SDA_OE} !== 2'b10) begin n_fail++; $display("FAIL mid_reset_bus got %b want 10", {I2C_SCL, I2C_SDA_OE}); end
        n_cmp++; if ({WORD_ST, WORD_CNT, WORD_BYTE} !== 24'h000000) begin n_fail++; $display("FAIL mid_reset_probe got %h want 000000", {WORD_ST, WORD_CNT, WORD_BYTE}); end
        for (int c = 0; c < 700; c++) begin if (W_WORD_END) ends++; @(posedge SYS_CLK); #1; end
        n_cmp++; if (ends !== 0) begin n_fail++; $display("FAIL mid_reset_no_end got %0d want 0", ends); end
        test_normal("after_reset");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal("normal");
        test_addr_nack();
        test_normal("ack_clear");
        test_data_nack();
        test_go_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
